// File: rtl/sram_pkg.sv
// sram_pkg: shared helpers and response type for the sram_bank data memory.
package sram_pkg;

    localparam int DEF_DATA_W = 64;

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int off_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic bit read_lat_ok(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

    typedef struct packed {
        logic [DEF_DATA_W-1:0] rdata;
        logic                  err;
        logic                  wr;
    } resp_t;

endpackage

// File: rtl/sram_resp_fifo.sv
// sram_resp_fifo: small synchronous FIFO holding responses until consumed.
module sram_resp_fifo
    import sram_pkg::*;
#(
    parameter type T     = resp_t,
    parameter int  DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  T                             din,
    input  logic                         pop,
    output T                             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                 store_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        do_pop   = pop && (count_q != '0);
        // a pop frees the slot being written when the FIFO is full
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        wr_ptr_d = do_push ? wrap_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? wrap_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            store_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = store_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/sram_bank.sv
// sram_bank: parametrised single-port memory bank with valid/ready request
// and response channels, in-order buffered responses and range checking.
module sram_bank
    import sram_pkg::*;
#(
    parameter int                DATA_W     = 64,
    parameter int                DEPTH      = 4096,
    parameter int                ADDR_W     = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 'h8000_0000,
    parameter int                READ_LAT   = 1,
    parameter int                RESP_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [strb_w(DATA_W)-1:0] req_we,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_wdata,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [DATA_W-1:0]         resp_rdata,
    output logic                      resp_err,
    output logic                      resp_wr
);

    localparam int STRB     = strb_w(DATA_W);
    localparam int OFF_BITS = off_bits(DATA_W);
    localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W    = $clog2(RESP_DEPTH + 1);

    if (!read_lat_ok(READ_LAT)) begin : g_bad_lat
        $error("sram_bank: READ_LAT must be 1 or 2");
    end

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
        logic              wr;
    } bank_resp_t;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              accept, pop, is_wr, addr_err;
    logic [ADDR_W-1:0] diff, word;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W:0]    outstanding;
    logic              pipe_cnt;
    bank_resp_t        new_resp, fifo_din, fifo_dout;
    logic              fifo_push, fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    always_comb begin
        diff     = req_addr - BASE_ADDR;
        word     = diff >> OFF_BITS;
        addr_err = (req_addr < BASE_ADDR) || (word >= ADDR_W'(DEPTH));
        idx      = word[IDX_W-1:0];
        is_wr    = |req_we;

        new_resp       = '0;
        new_resp.err   = addr_err;
        new_resp.wr    = is_wr;
        if (!addr_err && !is_wr) begin
            new_resp.rdata = mem_q[idx];
        end
    end

    always_comb begin
        pop         = !fifo_empty && resp_ready;
        outstanding = {1'b0, fifo_count} + (CNT_W + 1)'(pipe_cnt);
        // popping this cycle returns a credit immediately
        req_ready   = !rst && (!fifo_full || pop)
                    && ((outstanding < (CNT_W + 1)'(RESP_DEPTH)) || pop);
        accept      = req_valid && req_ready;
    end

    always_ff @(posedge clk) begin
        if (accept && is_wr && !addr_err) begin
            for (int b = 0; b < STRB; b++) begin
                if (req_we[b]) begin
                    mem_q[idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
                end
            end
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic       pipe_vld_q, pipe_vld_d;
        bank_resp_t pipe_q, pipe_d;

        always_comb begin
            pipe_vld_d = accept;
            pipe_d     = new_resp;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pipe_vld_q <= 1'b0;
                pipe_q     <= '0;
            end else begin
                pipe_vld_q <= pipe_vld_d;
                pipe_q     <= pipe_d;
            end
        end

        assign fifo_push = pipe_vld_q;
        assign fifo_din  = pipe_q;
        assign pipe_cnt  = pipe_vld_q;
    end else begin : g_lat1
        assign fifo_push = accept;
        assign fifo_din  = new_resp;
        assign pipe_cnt  = 1'b0;
    end

    sram_resp_fifo #(
        .T     (bank_resp_t),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign resp_valid = !fifo_empty;
    assign resp_rdata = fifo_empty ? '0 : fifo_dout.rdata;
    assign resp_err   = !fifo_empty && fifo_dout.err;
    assign resp_wr    = !fifo_empty && fifo_dout.wr;

endmodule

// File: tb/tb_sram_bank.sv
// tb_sram_bank: scoreboard bench driving a READ_LAT=1 and a READ_LAT=2 bank.
module tb_sram_bank;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        logic        wr;
        int          acc;
        bit          chk;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       resp_ready;
    logic [1:0][7:0]  req_we;
    logic [1:0][63:0] req_addr;
    logic [1:0][63:0] req_wdata;
    wire  [1:0]       req_ready;
    wire  [1:0]       resp_valid;
    wire  [1:0]       resp_err;
    wire  [1:0]       resp_wr;
    wire  [1:0][63:0] resp_rdata;

    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t mon_e;
    logic [1:0]       hold = '0;
    logic [1:0][65:0] last;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sram_bank #(.READ_LAT(g + 1)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_we     (req_we[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g]),
            .resp_wr    (resp_wr[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void qpush(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endfunction

    function automatic exp_t qpop(input int d);
        if (d == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    // Monitor: samples mid low phase, pops the scoreboard on each handshake
    always @(negedge clk) begin
        #2;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                hold[d] = 1'b0;
            end else begin
                if (hold[d])
                    check($sformatf("dut%0d hold", d),
                          {resp_rdata[d], resp_err[d], resp_wr[d]}, last[d]);
                if (resp_valid[d] && resp_ready[d]) begin
                    if (qsize(d) == 0) begin
                        nvec++;
                        nerr++;
                        $display("FAIL dut%0d unexpected: got resp %h expected none",
                                 d, resp_rdata[d]);
                    end else begin
                        mon_e = qpop(d);
                        check($sformatf("dut%0d resp", d),
                              {resp_rdata[d], resp_err[d], resp_wr[d]},
                              {mon_e.rdata, mon_e.err, mon_e.wr});
                        if (mon_e.chk)
                            check($sformatf("dut%0d latency", d),
                                  128'(cyc + 1 - mon_e.acc), 128'(d + 1));
                    end
                end
                hold[d] = resp_valid[d] && !resp_ready[d];
                last[d] = {resp_rdata[d], resp_err[d], resp_wr[d]};
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic issue(input int d, input logic [7:0] we,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] erd, input logic eerr, input bit chk);
        exp_t e;
        bit   ok;
        ok           = 0;
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        for (int t = 0; t < 40 && !ok; t++) begin
            #1;
            if (req_ready[d]) begin
                e.rdata = erd;
                e.err   = eerr;
                e.wr    = |we;
                e.acc   = cyc + 1;
                e.chk   = chk;
                qpush(d, e);
                ok = 1;
            end
            @(negedge clk);
        end
        if (!ok) begin
            nvec++;
            nerr++;
            $display("FAIL dut%0d accept timeout: addr %h never accepted", d, addr);
            req_valid[d] = 1'b0;
        end
    endtask

    task automatic rd(input int d, input logic [63:0] addr,
                      input logic [63:0] erd, input logic eerr, input bit chk);
        issue(d, 8'h00, addr, 64'h0, erd, eerr, chk);
    endtask

    task automatic idle(input int d, input int n);
        req_valid[d] = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input int d);
        req_valid[d]  = 1'b0;
        resp_ready[d] = 1'b1;
        for (int t = 0; t < 40 && qsize(d) != 0; t++) @(negedge clk);
        @(negedge clk);
        check($sformatf("dut%0d drain", d), 128'(qsize(d)), 128'(0));
    endtask

    function automatic logic [63:0] sdat(input int i);
        return {32'hC0DE_0000 + 32'(i), 32'h5A5A_0000 + 32'(i * 3)};
    endfunction

    task automatic run_suite(input int d);
        resp_ready[d] = 1'b1;
        issue(d, 8'hFF, 64'h8000_0010, 64'hDEAD_BEEF_0123_4567, 64'h0, 0, 1);
        rd(d, 64'h8000_0010, 64'hDEAD_BEEF_0123_4567, 0, 1);
        issue(d, 8'h0F, 64'h8000_0010, 64'h1111_1111_2222_2222, 64'h0, 0, 1);
        rd(d, 64'h8000_0010, 64'hDEAD_BEEF_2222_2222, 0, 1);
        rd(d, 64'h8000_0015, 64'hDEAD_BEEF_2222_2222, 0, 1);
        issue(d, 8'hFF, 64'h8000_0000, 64'h0BAD_F00D_0000_0001, 64'h0, 0, 1);
        issue(d, 8'hFF, 64'h8000_7FF8, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 1);
        rd(d, 64'h8000_7FF8, 64'h0123_4567_89AB_CDEF, 0, 1);
        rd(d, 64'h7FFF_FFF8, 64'h0, 1, 1);
        rd(d, 64'h8000_8000, 64'h0, 1, 1);
        issue(d, 8'hFF, 64'h8000_8000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, 1);
        rd(d, 64'h8000_0000, 64'h0BAD_F00D_0000_0001, 0, 1);
        rd(d, 64'h8000_0010, 64'hDEAD_BEEF_2222_2222, 0, 1);
        idle(d, 3);
        for (int i = 0; i < 16; i++)
            issue(d, 8'hFF, 64'h8000_0100 + 64'(i * 8), sdat(i), 64'h0, 0, 1);
        for (int i = 0; i < 16; i++)
            rd(d, 64'h8000_0100 + 64'(i * 8), sdat(i), 0, 1);
        idle(d, 3);
        resp_ready[d] = 1'b0;
        rd(d, 64'h8000_0100, sdat(0), 0, 0);
        rd(d, 64'h8000_0108, sdat(1), 0, 0);
        req_valid[d] = 1'b1;
        req_addr[d]  = 64'h8000_0110;
        req_we[d]    = 8'h00;
        #1 check($sformatf("dut%0d full stall", d), 128'(req_ready[d]), 128'(0));
        repeat (3) @(negedge clk);
        #1 check($sformatf("dut%0d still stalled", d), 128'(req_ready[d]), 128'(0));
        @(negedge clk);
        resp_ready[d] = 1'b1;
        rd(d, 64'h8000_0110, sdat(2), 0, 0);
        drain(d);
    endtask

    task automatic reset_test(input int d);
        resp_ready[d] = 1'b0;
        rd(d, 64'h8000_0100, sdat(0), 0, 0);
        rd(d, 64'h8000_0108, sdat(1), 0, 0);
        idle(d, 3);
        #1 check($sformatf("dut%0d queued", d), 128'(resp_valid[d]), 128'(1));
        #2 rst = 1'b1;
        #1;
        check($sformatf("dut%0d rst valid", d), 128'(resp_valid[d]), 128'(0));
        check($sformatf("dut%0d rst ready", d), 128'(req_ready[d]), 128'(0));
        check($sformatf("dut%0d rst outs", d),
              {resp_rdata[d], resp_err[d], resp_wr[d]}, 128'(0));
        if (d == 0) q0.delete();
        else q1.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check($sformatf("dut%0d post rst ready", d), 128'(req_ready[d]), 128'(1));
        check($sformatf("dut%0d post rst valid", d), 128'(resp_valid[d]), 128'(0));
        resp_ready[d] = 1'b1;
        @(negedge clk);
        idle(d, 4);
        rd(d, 64'h8000_0010, 64'hDEAD_BEEF_2222_2222, 0, 1);
        drain(d);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = '1;
        req_we     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        @(negedge clk);
        #1;
        check("reset req_ready", 128'(req_ready), 128'(0));
        check("reset resp_valid", 128'(resp_valid), 128'(0));
        check("reset resp_data", {resp_rdata, resp_err, resp_wr}, 128'(0));
        @(negedge clk);
        rst = 1'b0;
        #1 check("release req_ready", 128'(req_ready), 128'(3));
        @(negedge clk);
        for (int d = 0; d < 2; d++) run_suite(d);
        for (int d = 0; d < 2; d++) reset_test(d);
        idle(0, 4);
        check("final q0", 128'(q0.size()), 128'(0));
        check("final q1", 128'(q1.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
